// File: rtl/syst_feeder_if.sv
// Bundle of the write port, start/done handshake and the eight skewed
// operand lanes between the feeder and its neighbours.
interface syst_feeder_if #(
    parameter int DW = 32
);
    logic          wr_en;
    logic          wr_sel;
    logic [1:0]    wr_row;
    logic [1:0]    wr_col;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          arr_done;
    logic          busy;
    logic          feed_done;
    logic [DW-1:0] inp_w0;
    logic [DW-1:0] inp_w1;
    logic [DW-1:0] inp_w2;
    logic [DW-1:0] inp_w3;
    logic [DW-1:0] inp_n0;
    logic [DW-1:0] inp_n1;
    logic [DW-1:0] inp_n2;
    logic [DW-1:0] inp_n3;

    // Driver side: loads matrices, requests streaming, observes lanes.
    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start, arr_done,
        input  busy, feed_done,
        input  inp_w0, inp_w1, inp_w2, inp_w3,
        input  inp_n0, inp_n1, inp_n2, inp_n3
    );

    // Feeder side.
    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, arr_done,
        output busy, feed_done,
        output inp_w0, inp_w1, inp_w2, inp_w3,
        output inp_n0, inp_n1, inp_n2, inp_n3
    );
endinterface

// File: rtl/syst_feeder.sv
// Skewed operand feeder for a 4x4 systolic multiplier. Holds matrices A and B,
// streams them as diagonally skewed, zero-padded lanes for 7 steps on start,
// then waits for the array's done and emits a one-cycle completion pulse.
module syst_feeder #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    syst_feeder_if.slave  bus_if
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    t_q, t_d;

    logic [DW-1:0] a_q [4][4];
    logic [DW-1:0] b_q [4][4];

    logic [DW-1:0] w_d [4];
    logic [DW-1:0] n_d [4];
    logic [DW-1:0] w_q [4];
    logic [DW-1:0] n_q [4];

    logic          busy_d, busy_q;
    logic          feed_done_d, feed_done_q;
    logic          wr_ok;

    // A write lands only while idle and not in the same cycle as a start,
    // so operands cannot change under a stream that is being launched.
    assign wr_ok = bus_if.wr_en && (state_q == IDLE) && !bus_if.start;

    // State and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE and arr_done only in WAIT_DONE.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        feed_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                t_d = 3'd0;
                if (bus_if.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (t_q == 3'd6) begin
                    state_d = WAIT_DONE;
                    t_d     = 3'd0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            WAIT_DONE: begin
                if (bus_if.arr_done) begin
                    state_d     = IDLE;
                    feed_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = 3'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Operand storage; reset clears both matrices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (bus_if.wr_sel) begin
                b_q[bus_if.wr_row][bus_if.wr_col] <= bus_if.wr_data;
            end else begin
                a_q[bus_if.wr_row][bus_if.wr_col] <= bus_if.wr_data;
            end
        end
    end

    // Lane i is live for steps i..i+3; its offset into the row/column is t-i.
    // Lanes are computed from the next step so the registered output shows
    // step t right after the edge that enters it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [3:0] diff;
            logic       lane_en;
            assign diff    = {1'b0, t_d} - 4'(gi);
            assign lane_en = (state_d == STREAM) && (diff[3:2] == 2'b00);
            assign w_d[gi] = lane_en ? a_q[gi][diff[1:0]] : '0;
            assign n_d[gi] = lane_en ? b_q[diff[1:0]][gi] : '0;
        end
    endgenerate

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            feed_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
                n_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            feed_done_q <= feed_done_d;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= w_d[i];
                n_q[i] <= n_d[i];
            end
        end
    end

    assign bus_if.busy      = busy_q;
    assign bus_if.feed_done = feed_done_q;
    assign bus_if.inp_w0    = w_q[0];
    assign bus_if.inp_w1    = w_q[1];
    assign bus_if.inp_w2    = w_q[2];
    assign bus_if.inp_w3    = w_q[3];
    assign bus_if.inp_n0    = n_q[0];
    assign bus_if.inp_n1    = n_q[1];
    assign bus_if.inp_n2    = n_q[2];
    assign bus_if.inp_n3    = n_q[3];
endmodule

// File: tb/tb_syst_feeder.sv
// Directed bench for syst_feeder: load/stream, completion handshake, ignored
// inputs, asynchronous reset mid-stream, full-width data and early arr_done.
module tb_syst_feeder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    syst_feeder_if #(.DW(32)) bus ();

    syst_feeder #(.DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] lane_w(int i);
        case (i)
            0: return bus.inp_w0;
            1: return bus.inp_w1;
            2: return bus.inp_w2;
            default: return bus.inp_w3;
        endcase
    endfunction

    function automatic logic [31:0] lane_n(int i);
        case (i)
            0: return bus.inp_n0;
            1: return bus.inp_n1;
            2: return bus.inp_n2;
            default: return bus.inp_n3;
        endcase
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int r, input int c, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 2'(c);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Raise arr_done and wait (bounded) for the completion pulse.
    task automatic finish_op(input string name);
        bit seen;
        seen = 1'b0;
        bus.arr_done = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus.feed_done === 1'b1) seen = 1'b1;
        end
        bus.arr_done = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_feed_done got=0 exp=1 within 20 cycles", name);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.feed_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got busy=%b fd=%b exp busy=0 fd=0", bus.busy, bus.feed_done);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (lane_w(i) !== 32'd0 || lane_n(i) !== 32'd0) begin
                bad++;
                $display("FAIL reset_lane%0d got w=%h n=%h exp 0", i, lane_w(i), lane_n(i));
            end
        end
        #2 rst = 1'b0;
        tick();
        $display("reset: busy=%b feed_done=%b", bus.busy, bus.feed_done);
    endtask

    task automatic test_load_stream();
        logic [31:0] exp_w [4][7];
        logic [31:0] exp_n [4][7];
        exp_w[0] = '{1, 2, 3, 4, 0, 0, 0};
        exp_w[1] = '{0, 5, 6, 7, 8, 0, 0};
        exp_w[2] = '{0, 0, 9, 10, 11, 12, 0};
        exp_w[3] = '{0, 0, 0, 13, 14, 15, 16};
        exp_n[0] = '{1, 5, 9, 13, 0, 0, 0};
        exp_n[1] = '{0, 2, 6, 10, 14, 0, 0};
        exp_n[2] = '{0, 0, 3, 7, 11, 15, 0};
        exp_n[3] = '{0, 0, 0, 4, 8, 12, 16};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                wr(1'b0, r, c, 32'(4 * r + c + 1));
                wr(1'b1, r, c, 32'(4 * r + c + 1));
            end
        end
        do_start();
        for (int t = 0; t < 7; t++) begin
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL stream_busy step%0d got=%b exp=1", t, bus.busy);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (lane_w(i) !== exp_w[i][t] || lane_n(i) !== exp_n[i][t]) begin
                    bad++;
                    $display("FAIL stream_lane%0d step%0d got w=%0d n=%0d exp w=%0d n=%0d",
                             i, t, lane_w(i), lane_n(i), exp_w[i][t], exp_n[i][t]);
                end
            end
            $display("stream step %0d: w0=%0d w3=%0d n0=%0d n3=%0d", t,
                     bus.inp_w0, bus.inp_w3, bus.inp_n0, bus.inp_n3);
            if (t < 6) tick();
        end
    endtask

    task automatic test_completion();
        bus.arr_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (bus.busy !== 1'b1 || bus.feed_done !== 1'b0) begin
                bad++;
                $display("FAIL wait_flags cyc%0d got busy=%b fd=%b exp busy=1 fd=0", k, bus.busy, bus.feed_done);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (lane_w(i) !== 32'd0 || lane_n(i) !== 32'd0) begin
                    bad++;
                    $display("FAIL wait_lane%0d cyc%0d got w=%h n=%h exp 0", i, k, lane_w(i), lane_n(i));
                end
            end
        end
        bus.arr_done = 1'b1;
        tick();
        bus.arr_done = 1'b0;
        total++;
        if (bus.feed_done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got fd=%b busy=%b exp fd=1 busy=0", bus.feed_done, bus.busy);
        end
        tick();
        total++;
        if (bus.feed_done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_after got fd=%b busy=%b exp fd=0 busy=0", bus.feed_done, bus.busy);
        end
        $display("completion: feed_done pulse observed, busy=%b", bus.busy);
    endtask

    task automatic test_ignored();
        do_start();
        // Write A[0][0]=99 and re-assert start while streaming.
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = 32'd99;
        bus.start   = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        total++;
        if (bus.inp_w0 !== 32'd2) begin
            bad++;
            $display("FAIL ign_no_restart got w0=%0d exp=2", bus.inp_w0);
        end
        tick();
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.inp_w3 !== 32'd14) begin
            bad++;
            $display("FAIL ign_step4 got busy=%b w3=%0d exp busy=1 w3=14", bus.busy, bus.inp_w3);
        end
        tick();
        tick();
        tick();
        finish_op("ign1");
        // Write and start together in the first IDLE cycle after feed_done.
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = 32'd77;
        bus.start   = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.inp_w0 !== 32'd1) begin
            bad++;
            $display("FAIL ign_wr_start got busy=%b w0=%0d exp busy=1 w0=1", bus.busy, bus.inp_w0);
        end
        $display("ignored: A00 streamed as %0d", bus.inp_w0);
        for (int k = 0; k < 6; k++) tick();
        finish_op("ign2");
    endtask

    task automatic test_reset_midstream();
        do_start();
        tick();
        tick();
        tick();
        total++;
        if (bus.inp_w3 !== 32'd13) begin
            bad++;
            $display("FAIL rstmid_pre got w3=%0d exp=13", bus.inp_w3);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.feed_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flags got busy=%b fd=%b exp 0/0", bus.busy, bus.feed_done);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (lane_w(i) !== 32'd0 || lane_n(i) !== 32'd0) begin
                bad++;
                $display("FAIL rstmid_lane%0d got w=%h n=%h exp 0", i, lane_w(i), lane_n(i));
            end
        end
        tick();
        #2 rst = 1'b0;
        tick();
        do_start();
        for (int t = 0; t < 7; t++) begin
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_busy step%0d got=%b exp=1", t, bus.busy);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (lane_w(i) !== 32'd0 || lane_n(i) !== 32'd0) begin
                    bad++;
                    $display("FAIL rstmid_zero lane%0d step%0d got w=%h n=%h exp 0", i, t, lane_w(i), lane_n(i));
                end
            end
            if (t < 6) tick();
        end
        $display("reset mid-stream: post-reset stream all zero");
        finish_op("rstmid");
    endtask

    task automatic test_full_width();
        logic [31:0] ew;
        logic [31:0] en;
        wr(1'b0, 2, 1, 32'hFFFF_FFFF);
        wr(1'b1, 1, 2, 32'h8000_0001);
        do_start();
        for (int t = 0; t < 7; t++) begin
            ew = (t == 3) ? 32'hFFFF_FFFF : 32'd0;
            en = (t == 3) ? 32'h8000_0001 : 32'd0;
            total++;
            if (bus.inp_w2 !== ew || bus.inp_n2 !== en) begin
                bad++;
                $display("FAIL wide step%0d got w2=%h n2=%h exp w2=%h n2=%h", t, bus.inp_w2, bus.inp_n2, ew, en);
            end
            $display("wide step %0d: w2=%h n2=%h", t, bus.inp_w2, bus.inp_n2);
            if (t < 6) tick();
        end
        finish_op("wide");
    endtask

    task automatic test_early_done();
        do_start();                 // edge 0 -> step 0
        tick();                     // step 1
        tick();                     // step 2
        bus.arr_done = 1'b1;
        for (int e = 3; e <= 8; e++) begin
            tick();
            if (e <= 6) begin
                total++;
                if (bus.busy !== 1'b1 || bus.feed_done !== 1'b0) begin
                    bad++;
                    $display("FAIL early_step%0d got busy=%b fd=%b exp busy=1 fd=0", e, bus.busy, bus.feed_done);
                end
            end
            if (e == 3) begin
                total++;
                if (bus.inp_w2 !== 32'hFFFF_FFFF) begin
                    bad++;
                    $display("FAIL early_w2 got=%h exp=ffffffff", bus.inp_w2);
                end
            end
            if (e == 7) begin
                total++;
                if (bus.busy !== 1'b1 || bus.feed_done !== 1'b0 || bus.inp_w3 !== 32'd0) begin
                    bad++;
                    $display("FAIL early_wait got busy=%b fd=%b w3=%h exp busy=1 fd=0 w3=0",
                             bus.busy, bus.feed_done, bus.inp_w3);
                end
            end
            if (e == 8) begin
                total++;
                if (bus.feed_done !== 1'b1 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL early_done got fd=%b busy=%b exp fd=1 busy=0", bus.feed_done, bus.busy);
                end
            end
        end
        bus.arr_done = 1'b0;
        tick();
        total++;
        if (bus.feed_done !== 1'b0) begin
            bad++;
            $display("FAIL early_pulse_width got fd=%b exp=0", bus.feed_done);
        end
        $display("early done: feed_done 8 cycles after start");
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_row   = 2'd0;
        bus.wr_col   = 2'd0;
        bus.wr_data  = 32'd0;
        bus.start    = 1'b0;
        bus.arr_done = 1'b0;
        #1;
        test_reset();
        test_load_stream();
        test_completion();
        test_ignored();
        test_reset_midstream();
        test_full_width();
        test_early_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
